// File: rtl/fanout_pkg.sv
// Shared defaults and types for the fanout fork stage.
package fanout_pkg;

    localparam int FANOUT_NUM_OUT_DEFAULT = 6;
    localparam int FANOUT_DATA_W_DEFAULT  = 17;

    typedef logic [FANOUT_NUM_OUT_DEFAULT-1:0] fanout_mask_t;

endpackage

// File: rtl/fanout_fifo2.sv
// Two-entry input buffer for the fanout fork; slot0 is always the head.
module fanout_fifo2
    import fanout_pkg::*;
#(
    parameter int DATA_W = FANOUT_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              head_valid,
    output logic              full
);

    logic [1:0]        count;
    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (pop) begin
            slot0 <= (count == 2'd2) ? slot1 : din;
            if (push) begin
                slot1 <= din;
            end
        end else if (push) begin
            if (count == 2'd0) begin
                slot0 <= din;
            end else begin
                slot1 <= din;
            end
        end
    end

    assign head       = slot0;
    assign head_valid = (count != 2'd0);
    assign full       = (count == 2'd2);

endmodule

// File: rtl/fanout_fork.sv
// Eager fork: broadcasts each buffered token to all participating outputs.
// Optional retired-token counter enabled by the FANOUT_STATS_EN macro.
module fanout_fork
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = FANOUT_NUM_OUT_DEFAULT,
    parameter int DATA_W  = FANOUT_DATA_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_OUT-1:0] route_en,
    input  logic [NUM_OUT-1:0] route_sel,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready
`ifdef FANOUT_STATS_EN
    ,
    output logic [15:0]        token_count
`endif
);

    logic [NUM_OUT-1:0] mask;
    logic [NUM_OUT-1:0] sent;
    logic [DATA_W-1:0]  head;
    logic               head_valid;
    logic               full;
    logic               push;
    logic               complete;

    // in_ready comes from buffer occupancy only, never from out_ready.
    assign in_ready = ~full & ~reset;
    assign push     = in_valid & in_ready;

    fanout_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (complete),
        .din       (in_data),
        .head      (head),
        .head_valid(head_valid),
        .full      (full)
    );

    assign mask      = route_en & route_sel;
    assign out_valid = {NUM_OUT{head_valid}} & mask & ~sent;
    assign out_data  = head_valid ? head : '0;
    // An output is done if it does not participate, already took the token, or takes it now.
    assign complete  = head_valid & (&(~mask | sent | out_ready));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sent <= '0;
        end else if (complete) begin
            sent <= '0;
        end else begin
            sent <= sent | (out_valid & out_ready);
        end
    end

`ifdef FANOUT_STATS_EN
    function automatic logic [15:0] wrap_inc(input logic [15:0] v);
        return v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            token_count <= 16'd0;
        end else if (complete && (|mask)) begin
            token_count <= wrap_inc(token_count);
        end
    end
`endif

endmodule

// File: tb/tb_fanout_fork.sv
// Scoreboard bench for fanout_fork; counter checks compile in with FANOUT_STATS_EN.
module tb_fanout_fork;
    import fanout_pkg::*;

    localparam int NUM_OUT = FANOUT_NUM_OUT_DEFAULT;
    localparam int DATA_W  = FANOUT_DATA_W_DEFAULT;

    logic               clk = 1'b0;
    logic               reset;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    fanout_mask_t       route_en;
    fanout_mask_t       route_sel;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
`ifdef FANOUT_STATS_EN
    logic [15:0]        token_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] sbq [NUM_OUT][$];

    always #5 clk = ~clk;

    fanout_fork #(
        .NUM_OUT(NUM_OUT),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .route_en   (route_en),
        .route_sel  (route_sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef FANOUT_STATS_EN
        ,
        .token_count(token_count)
`endif
    );

    // Scoreboard: expected tokens queued per destination at push, consumed per beat.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) sbq[i].delete();
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    n_cmp++;
                    if (sbq[i].size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_extra_beat out%0d: got data %h, expected no beat", i, out_data);
                    end else begin
                        logic [DATA_W-1:0] exp_d;
                        exp_d = sbq[i].pop_front();
                        if (out_data !== exp_d) begin
                            n_bad++;
                            $display("FAIL sb_data out%0d: got %h, expected %h", i, out_data, exp_d);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < NUM_OUT; i++)
                    if (route_en[i] && route_sel[i]) sbq[i].push_back(in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tok(input logic [DATA_W-1:0] d);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50 && !done; k++) begin
            if (in_ready) done = 1;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: in_ready never rose for %h", d);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
`ifdef FANOUT_STATS_EN
        n_cmp++; if (token_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d, expected 0", token_count); end
`endif
        step();
        reset = 1'b0;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_broadcast();
`ifdef FANOUT_STATS_EN
        logic [15:0] c0 = token_count;
`endif
        route_en  = 6'b000111;
        route_sel = 6'b000111;
        out_ready = '1;
        push_tok(17'h000A5);
        n_cmp++; if (out_valid !== 6'b000111) begin n_bad++; $display("FAIL bc_valid: got %b, expected 000111", out_valid); end
        n_cmp++; if (out_data !== 17'h000A5) begin n_bad++; $display("FAIL bc_data: got %h, expected 000a5", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bc_in_ready: got %b, expected 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL bc_retired: got %b, expected 0", out_valid); end
`ifdef FANOUT_STATS_EN
        n_cmp++; if (token_count !== c0 + 16'd1) begin n_bad++; $display("FAIL bc_count: got %0d, expected %0d", token_count, c0 + 16'd1); end
`endif
    endtask

    task automatic test_partial();
        route_en  = 6'b000011;
        route_sel = 6'b111111;
        out_ready = 6'b000001;
        push_tok(17'h11234);
        n_cmp++; if (out_valid !== 6'b000011) begin n_bad++; $display("FAIL pa_c1: got %b, expected 000011", out_valid); end
        step();
        n_cmp++; if (out_valid !== 6'b000010) begin n_bad++; $display("FAIL pa_c2: got %b, expected 000010", out_valid); end
        step();
        n_cmp++; if (out_valid !== 6'b000010) begin n_bad++; $display("FAIL pa_c3: got %b, expected 000010", out_valid); end
        n_cmp++; if (out_data !== 17'h11234) begin n_bad++; $display("FAIL pa_hold: got %h, expected 11234", out_data); end
        out_ready = 6'b000010;
        #1;
        n_cmp++; if (out_valid !== 6'b000010) begin n_bad++; $display("FAIL pa_c4: got %b, expected 000010", out_valid); end
        step();
        n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL pa_retire: got %b, expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        route_en  = 6'b101101;
        route_sel = 6'b111101;
        out_ready = '0;
        in_valid  = 1'b1;
        in_data   = 17'h00111;
        step();
        in_data = 17'h10222;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_c1: got %b, expected 1", in_ready); end
        step();
        in_data = 17'h00333;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got %b, expected 0", in_ready); end
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_refused: got %b, expected 0", in_ready); end
        n_cmp++; if (out_data !== 17'h00111) begin n_bad++; $display("FAIL bp_head: got %h, expected 00111", out_data); end
        out_ready = '1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_no_comb_path: got %b, expected 0", in_ready); end
        n_cmp++; if (out_valid !== 6'b101101) begin n_bad++; $display("FAIL bp_valid1: got %b, expected 101101", out_valid); end
        step();
        n_cmp++; if (out_data !== 17'h10222) begin n_bad++; $display("FAIL bp_tok2: got %h, expected 10222", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b, expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_data !== 17'h00333) begin n_bad++; $display("FAIL bp_tok3: got %h, expected 00333", out_data); end
        n_cmp++; if (out_valid !== 6'b101101) begin n_bad++; $display("FAIL bp_valid3: got %b, expected 101101", out_valid); end
        step();
        n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL bp_drained: got %b, expected 0", out_valid); end
    endtask

    task automatic test_zero_mask();
`ifdef FANOUT_STATS_EN
        logic [15:0] c0 = token_count;
`endif
        int accepted = 0;
        int seen     = 0;
        route_en  = '0;
        route_sel = '1;
        out_ready = '1;
        in_valid  = 1'b1;
        for (int k = 0; k < 20 && accepted < 5; k++) begin
            in_data = DATA_W'(17'h00500 + k);
            if (out_valid !== '0) seen++;
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (out_valid !== '0) seen++;
            step();
        end
        n_cmp++; if (accepted !== 5) begin n_bad++; $display("FAIL zm_accepted: got %0d, expected 5", accepted); end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL zm_valid: got %0d valid cycles, expected 0", seen); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL zm_empty: got in_ready %b, expected 1", in_ready); end
`ifdef FANOUT_STATS_EN
        n_cmp++; if (token_count !== c0) begin n_bad++; $display("FAIL zm_count: got %0d, expected %0d", token_count, c0); end
`endif
    endtask

    task automatic test_reset_mid();
        route_en  = 6'b110000;
        route_sel = 6'b110000;
        out_ready = 6'b010000;
        push_tok(17'h0BEEF);
        n_cmp++; if (out_valid !== 6'b110000) begin n_bad++; $display("FAIL rm_c1: got %b, expected 110000", out_valid); end
        step();
        n_cmp++; if (out_valid !== 6'b100000) begin n_bad++; $display("FAIL rm_c2: got %b, expected 100000", out_valid); end
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL rm_valid: got %b, expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rm_in_ready: got %b, expected 0", in_ready); end
        step();
        reset = 1'b0;
        step();
        n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL rm_discard: got %b, expected 0", out_valid); end
        out_ready = 6'b110000;
        push_tok(17'h1CAFE);
        n_cmp++; if (out_valid !== 6'b110000) begin n_bad++; $display("FAIL rm_next: got %b, expected 110000", out_valid); end
        n_cmp++; if (out_data !== 17'h1CAFE) begin n_bad++; $display("FAIL rm_next_data: got %h, expected 1cafe", out_data); end
        step();
        n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL rm_next_retire: got %b, expected 0", out_valid); end
    endtask

`ifdef FANOUT_STATS_EN
    task automatic test_wrap();
        int accepted = 0;
        do_reset();
        route_en  = 6'b000001;
        route_sel = 6'b000001;
        out_ready = '1;
        in_valid  = 1'b1;
        for (int k = 0; k < 70000 && accepted < 65537; k++) begin
            in_data = DATA_W'(k);
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        n_cmp++; if (accepted !== 65537) begin n_bad++; $display("FAIL wr_accepted: got %0d, expected 65537", accepted); end
        n_cmp++; if (token_count !== 16'd1) begin n_bad++; $display("FAIL wr_count: got %0d, expected 1", token_count); end
    endtask
`endif

    task automatic test_drained();
        step();
        for (int i = 0; i < NUM_OUT; i++) begin
            n_cmp++;
            if (sbq[i].size() != 0) begin
                n_bad++;
                $display("FAIL sb_leftover out%0d: got %0d undelivered, expected 0", i, sbq[i].size());
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        route_en  = '0;
        route_sel = '0;
        out_ready = '0;
        test_reset();
        test_broadcast();
        test_partial();
        test_backpressure();
        test_zero_mask();
        test_reset_mid();
        test_drained();
`ifdef FANOUT_STATS_EN
        test_wrap();
        test_drained();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fanout_fork.md
# fanout_fork

Eager fork stage that broadcasts one input stream to up to NUM_OUT downstream consumers and retires each token only once every participating consumer has accepted it. It sits directly upstream of the fanout ready-aggregation logic in a configured routing path. Its per-output enable, select and ready signals feed that aggregation, and its own completion condition is the same AND-reduction: for each output, not enabled, not selected, or ready. A 2-entry input buffer decouples upstream ready from downstream ready.

## Interface
- NUM_OUT, 6: number of fanout destinations.
- DATA_W, 17: token width, including the control bit.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  upstream token.
- in_valid  in  1  upstream valid.
- in_ready  out  1  upstream ready, driven from registered state only.
- route_en  in  NUM_OUT  per-destination enable; quasi-static configuration.
- route_sel  in  NUM_OUT  per-destination decoded select bit; quasi-static configuration.
- out_data  out  DATA_W  head token, shared by all destinations.
- out_valid  out  NUM_OUT  per-destination valid.
- out_ready  in  NUM_OUT  per-destination ready.
- token_count  out  16  retired-token counter; present only with FANOUT_STATS_EN.

## Operation
- Participation mask: mask[i] = route_en[i] & route_sel[i]. It is combinational and evaluated against the current head token. Configuration must be held stable while any token is buffered; behaviour is undefined otherwise.
- Buffer: 2-entry FIFO with count 0..2.
  - Push on in_valid & in_ready.
  - Pop on head completion.
- Per-destination sent[i] flag, one register per output.
- Output valid: out_valid[i] = head_valid & mask[i] & ~sent[i].
- A transfer to destination i occurs on out_valid[i] & out_ready[i]. If the head does not complete in that cycle, sent[i] is set.
- Completion: head_valid and, for every i, (~mask[i] | sent[i] | out_ready[i]).
  - On completion: pop the head and clear all sent flags in the same cycle.
  - An all-zero mask completes immediately, so the token is dropped one cycle after it is buffered.
- out_data = head entry. It holds steady while the head is not retired.
- Simultaneous push and pop: legal at count 1. Count stays 1, the new token becomes head next cycle, and sent stays cleared.
- At count 2, in_ready = 0 even if the head completes that cycle. There is no combinational out_ready to in_ready path.
- Reset: asserted at any time, it clears immediately. Count = 0, sent = 0, out_valid = 0, token_count = 0. A buffered token is discarded.

## Timing
- in_ready = (count != 2) & ~reset. Reset value 0. It reads 1 in the first cycle after reset deasserts.
- Latency: token accepted in cycle t → out_valid high in cycle t+1 (when it is head).
- Throughput: 1 token per cycle when all participating destinations are ready.
- out_valid depends combinationally on route_en and route_sel, and on registered state only. It never depends on out_ready.
- Reset values: out_valid = 0, out_data = 0, token_count = 0.

## Configuration
- FANOUT_STATS_EN defined:
  - token_count port exists.
  - Increments by 1 on each completion with a nonzero mask.
  - Wraps from 0xFFFF to 0.
  - Dropped (all-zero-mask) tokens are not counted.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package fanout_pkg holds:
  - Constants FANOUT_NUM_OUT_DEFAULT = 6 and FANOUT_DATA_W_DEFAULT = 17.
  - Typedef fanout_mask_t (logic [NUM_OUT-1:0]).
- One sub-module, fanout_fifo2: 2-entry FIFO with push, pop, head, head_valid, full and async active-high reset.
- The fork and completion logic stays in the top level.

## Test plan
- Basic broadcast: route_en = route_sel = 6'b000111, all out_ready = 1. Push 0x00A5 → out_valid = 6'b000111 next cycle, token retired that cycle, in_ready stays 1.
- Eager partial accept: mask = 6'b000011, out_ready = 6'b000001 for 3 cycles then 6'b000010.
  - Expected: out_valid[0] drops after cycle 1 and out_valid[1] stays high.
  - Token retires in cycle 4; out0 receives exactly 1 beat.
- Backpressure: all out_ready = 0, push 3 tokens.
  - Expected: the 3rd is refused (in_ready = 0 after 2 accepted).
  - Raise all ready: tokens emerge in order, 1 per cycle.
- Zero mask: route_en = 0. Push 5 tokens → each dropped, out_valid stays 0, token_count stays 0 (FANOUT_STATS_EN).
- Reset mid-token: mask = 6'b110000, out_ready = 6'b010000, then assert reset.
  - Expected: out_valid = 0 and in_ready = 0 immediately.
  - After release: count = 0, sent cleared, next token delivered to both outputs.
- Counter wrap: with FANOUT_STATS_EN, retire 65537 tokens with mask = 6'b000001 → token_count = 1.
